// File: rtl/irq_ack_sequencer.sv
// Presents controller interrupts to the CPU one at a time, then acknowledges
// each serviced interrupt with a single APB write to the controller ACK register.
module irq_ack_sequencer #(
    parameter logic [4:0]  ACK_ADDR       = 5'h10,
    parameter int unsigned HOLDOFF_CYCLES = 4,
    parameter int unsigned TAKE_TIMEOUT   = 255
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [3:0]  INT,
    input  logic [4:0]  IRQ_VECTOR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [4:0]  PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    output logic        cpu_irq_req,
    output logic [1:0]  cpu_irq_line,
    output logic [4:0]  cpu_irq_vector,
    input  logic        cpu_irq_take,
    input  logic        cpu_eoi,
    output logic        busy,
    output logic        ack_err,
    output logic        timeout_pulse
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_REQ        = 3'd1;
    localparam logic [2:0] S_SERVICE    = 3'd2;
    localparam logic [2:0] S_ACK_SETUP  = 3'd3;
    localparam logic [2:0] S_ACK_ACCESS = 3'd4;
    localparam logic [2:0] S_HOLDOFF    = 3'd5;

    // Last count value before leaving REQ / HOLDOFF; the counter starts at 0.
    localparam logic [7:0] TAKE_LAST = 8'(TAKE_TIMEOUT - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF_CYCLES - 1);

    logic [2:0]  state;
    logic [2:0]  state_n;
    logic [7:0]  cnt;
    logic [7:0]  cnt_n;
    logic [1:0]  line_n;
    logic [4:0]  vector_n;
    logic        timeout_n;
    logic        ack_err_n;
    logic        apb_n;
    logic        unused_prdata;

    assign unused_prdata = ^PRDATA;

    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        logic [1:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (v[i] && !found) begin
                idx   = 2'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        line_n    = cpu_irq_line;
        vector_n  = cpu_irq_vector;
        timeout_n = 1'b0;
        ack_err_n = ack_err;
        case (state)
            S_IDLE: begin
                if (INT != '0) begin
                    state_n  = S_REQ;
                    cnt_n    = '0;
                    line_n   = lowest_set(INT);
                    vector_n = IRQ_VECTOR;
                end
            end
            S_REQ: begin
                // Take wins over an expiring timeout; EOI has no meaning here.
                if (cpu_irq_take) begin
                    state_n = S_SERVICE;
                end else if (cnt >= TAKE_LAST) begin
                    state_n   = S_HOLDOFF;
                    cnt_n     = '0;
                    timeout_n = 1'b1;
                end else begin
                    cnt_n = sat_inc(cnt);
                end
            end
            S_SERVICE: begin
                if (cpu_eoi) begin
                    state_n = S_ACK_SETUP;
                end
            end
            S_ACK_SETUP: begin
                state_n = S_ACK_ACCESS;
            end
            S_ACK_ACCESS: begin
                if (PREADY) begin
                    state_n = S_HOLDOFF;
                    cnt_n   = '0;
                    if (PSLVERR) begin
                        ack_err_n = 1'b1;
                    end
                end
            end
            S_HOLDOFF: begin
                if (cnt >= HOLD_LAST) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = sat_inc(cnt);
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign apb_n = (state_n == S_ACK_SETUP) || (state_n == S_ACK_ACCESS);

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            cpu_irq_line   <= '0;
            cpu_irq_vector <= '0;
            cpu_irq_req    <= 1'b0;
            busy           <= 1'b0;
            ack_err        <= 1'b0;
            timeout_pulse  <= 1'b0;
            PSEL           <= 1'b0;
            PENABLE        <= 1'b0;
            PWRITE         <= 1'b0;
            PADDR          <= '0;
            PWDATA         <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            cpu_irq_line   <= line_n;
            cpu_irq_vector <= vector_n;
            cpu_irq_req    <= (state_n == S_REQ);
            busy           <= (state_n != S_IDLE);
            ack_err        <= ack_err_n;
            timeout_pulse  <= timeout_n;
            PSEL           <= apb_n;
            PENABLE        <= (state_n == S_ACK_ACCESS);
            PWRITE         <= apb_n;
            PADDR          <= apb_n ? ACK_ADDR : '0;
            PWDATA         <= apb_n ? (32'd1 << vector_n) : '0;
        end
    end

endmodule

// File: doc/irq_ack_sequencer.md
# irq_ack_sequencer

Downstream consumer of the interrupt controller's `INT[3:0]` and `IRQ_VECTOR[4:0]` outputs. It presents one interrupt at a time to the CPU core through a req/take/EOI handshake. On EOI it acts as an APB master and writes the one-hot acknowledge word to the controller's ACK register, closing the loop. It then holds off re-arbitration for a fixed window so the controller's registered `INT` can settle.

## Interface
- `ACK_ADDR`, default 5'h10: APB address of the controller ACK register.
- `HOLDOFF_CYCLES`, default 4: idle cycles after the ACK write completes before `INT` is sampled again (range 1-255).
- `TAKE_TIMEOUT`, default 255: maximum cycles `cpu_irq_req` stays high without `cpu_irq_take` (range 1-255).

Ports:
- `pclk` in 1: single clock, shared with the APB bus.
- `rst` in 1: synchronous, active-high reset.
- `INT` in 4: interrupt lines from the controller.
- `IRQ_VECTOR` in 5: vector from the controller. Software programs the vector table so that vector equals the source index.
- `PSEL`, `PENABLE`, `PWRITE` out 1 each: APB master controls.
- `PADDR` out 5: APB address.
- `PWDATA` out 32: APB write data.
- `PRDATA` in 32: APB read data. Unused; writes only.
- `PREADY` in 1: APB ready.
- `PSLVERR` in 1: APB slave error.
- `cpu_irq_req` out 1: request to the CPU.
- `cpu_irq_line` out 2: index of the `INT` line being serviced.
- `cpu_irq_vector` out 5: latched vector.
- `cpu_irq_take` in 1: CPU accepts the request.
- `cpu_eoi` in 1: CPU end-of-interrupt pulse.
- `busy` out 1: the FSM is not in IDLE.
- `ack_err` out 1: sticky flag, set on `PSLVERR` during the ACK write.
- `timeout_pulse` out 1: one-cycle pulse when a request is abandoned.

## Operation
States: IDLE, REQ, SERVICE, ACK_SETUP, ACK_ACCESS, HOLDOFF.

- **IDLE**
  - If `INT != 0`: latch `cpu_irq_line` as the lowest set bit index and `cpu_irq_vector = IRQ_VECTOR`, clear the timeout counter, go to REQ.
  - Otherwise stay in IDLE.
- **REQ**
  - `cpu_irq_req = 1`.
  - `cpu_irq_take` sampled high: go to SERVICE.
  - Otherwise, when the counter reaches `TAKE_TIMEOUT`: pulse `timeout_pulse` and go to HOLDOFF. No ACK write is issued.
  - `cpu_eoi` is ignored in REQ, including when it coincides with take.
- **SERVICE**
  - Waits indefinitely for `cpu_eoi`, then goes to ACK_SETUP.
  - `cpu_irq_take` is ignored.
- **ACK_SETUP**
  - Drives `PSEL=1`, `PENABLE=0`, `PWRITE=1`, `PADDR=ACK_ADDR`, `PWDATA = 32'b1 << cpu_irq_vector`.
  - Always one cycle, then ACK_ACCESS.
- **ACK_ACCESS**
  - Same address, data and control as ACK_SETUP, with `PENABLE=1`.
  - Held through any number of wait states until `PREADY=1`, then go to HOLDOFF.
  - If `PSLVERR=1` in the `PREADY` cycle, set `ack_err`. There is no retry.
- **HOLDOFF**
  - Counts `HOLDOFF_CYCLES` cycles, then returns to IDLE.
  - `INT` is not sampled during this state.

Output and width rules:
- `cpu_irq_line` and `cpu_irq_vector` hold their latched values from IDLE exit until the next latch.
- `ack_err` is cleared only by `rst`.
- Outside the two ACK states, `PSEL`, `PENABLE` and `PWRITE` are 0, and `PADDR`/`PWDATA` are 0.
- All APB outputs are registered, so they are glitch-free.
- Counters are 8 bits and saturate; they never wrap.

## Timing
- **Reset:** state IDLE; all outputs 0, including `cpu_irq_req`, `cpu_irq_line`, `cpu_irq_vector`, `busy`, `ack_err`, `timeout_pulse`, and all APB outputs.
- **Reset mid-transaction:** `rst` asserted during any state, including mid APB access, forces IDLE at the next edge. `PSEL` drops with no completion.
- **Cycle latencies:**
  - `INT` nonzero at edge N: `cpu_irq_req=1` from N+1.
  - Take sampled at edge M: `cpu_irq_req=0` from M+1.
  - EOI sampled at edge K: `PSEL=1` from K+1; `PENABLE=1` from K+2.
  - `PREADY` sampled at edge P: APB outputs low from P+1; IDLE from P+1+`HOLDOFF_CYCLES`.
- **Minimum turnaround:** from EOI to the next possible latch is 3+`HOLDOFF_CYCLES` cycles with zero wait states.
- **Timeout:** `timeout_pulse` is asserted in the cycle after the `TAKE_TIMEOUT`-th REQ cycle.
- **`busy`:** equals `state != IDLE`, registered.

## Test plan
- **Basic handshake:** `INT=4'b0100`, `IRQ_VECTOR=5`; take 2 cycles later; EOI 3 cycles later; `PREADY` immediate. Expect `cpu_irq_line=2` and `cpu_irq_vector=5`. Expect exactly one APB write to 5'h10 with `PWDATA=32'h0000_0020`. Expect a return to IDLE after 4 holdoff cycles.
- **Line priority and wait states:** `INT=4'b1010`. Expect `cpu_irq_line=1`. `PREADY` held low for 3 access cycles: `PSEL`, `PENABLE`, `PADDR` and `PWDATA` stay stable, and exactly one write completes.
- **Take timeout:** `TAKE_TIMEOUT=8`, take never asserted. Expect `cpu_irq_req` high for 8 cycles, then a one-cycle `timeout_pulse`, then no APB activity and a return to IDLE.
- **Slave error:** `PSLVERR=1` with `PREADY`. Expect `ack_err=1` and no retry. `ack_err` stays set through a later clean interrupt and clears only on `rst`.
- **Reset mid-access:** assert `rst` in ACK_ACCESS. Expect `PSEL=0` and all outputs 0 at the next edge. With `INT` still set after reset, expect a fresh REQ one cycle after `rst` deasserts.
- **Take/EOI overlap:** `cpu_eoi` and `cpu_irq_take` high in the same REQ cycle. Expect the EOI to be ignored, SERVICE entered, and the ACK write issued only after a later EOI.
